gravity_refill: RTL and testbench

- Post-elimination stage of the 8x8 match game datapath.
- Consumes the board produced by the eliminate stage. In that board, cleared cells hold the EMPTY code.
- Drops surviving tiles toward the bottom of each column, then fills the vacated top cells with pseudo-random colours from an internal LFSR.
- Hands the settled board back to eliminate for the next match check, with a done pulse.

---
 rtl/gravity_refill.sv | 168 ++++++++++++++++
 tb/tb_gravity_refill.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gravity_refill.sv
// gravity_refill: settles an 8x8 match-game board after elimination.
// Surviving tiles fall to the bottom of each column one column per cycle.
// Vacated cells are then refilled from a 16-bit LFSR, again one column per cycle.
module gravity_refill #(
  parameter int          NUM_COLORS = 6,
  parameter logic [2:0]  EMPTY      = 3'd0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] board_in,
  output logic [191:0] board_out,
  output logic         busy,
  output logic         done,
  output logic [6:0]   refill_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPACT,
    S_REFILL,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [2:0]   r_col;
  logic [15:0]  r_lfsr;
  logic [191:0] r_board;
  logic [6:0]   r_refillCnt;
  logic         r_busy;
  logic         r_done;

  logic [2:0]   w_colIn   [8];
  logic [2:0]   w_compCol [8];
  logic [2:0]   w_fillCol [8];
  logic [2:0]   w_win     [8];
  logic [3:0]   w_slot;
  logic [6:0]   w_fillCount;
  logic [15:0]  w_lfsrNext;
  logic [191:0] w_boardNext;

  // Map a 3-bit random window onto a legal colour 1..NUM_COLORS.
  function automatic logic [2:0] colourOf(input logic [2:0] win);
    int m;
    m = (int'(win) % NUM_COLORS) + 1;
    return m[2:0];
  endfunction

  // Gather the cells of the column currently being worked on, top row first.
  always_comb begin
    w_colIn = '{default: EMPTY};
    for (int r = 0; r < 8; r++) begin
      w_colIn[r] = r_board[(r * 8 + int'(r_col)) * 3 +: 3];
    end
  end

  // Pack the column's tiles to the bottom, keeping their top-to-bottom order.
  always_comb begin
    w_compCol = '{default: EMPTY};
    w_slot    = 4'd7;
    for (int r = 7; r >= 0; r--) begin
      if (w_colIn[r] != EMPTY) begin
        w_compCol[w_slot[2:0]] = w_colIn[r];
        w_slot                 = w_slot - 4'd1;
      end
    end
  end

  // Random windows per row; the bottom row wraps around the top of the LFSR.
  always_comb begin
    w_win = '{default: 3'd0};
    for (int r = 0; r < 7; r++) begin
      w_win[r] = r_lfsr[2 * r +: 3];
    end
    w_win[7] = {r_lfsr[0], r_lfsr[15:14]};
  end

  // Fill the empty cells of the current column and count how many were filled.
  always_comb begin
    w_fillCol   = w_colIn;
    w_fillCount = 7'd0;
    for (int r = 0; r < 8; r++) begin
      if (w_colIn[r] == EMPTY) begin
        w_fillCol[r] = colourOf(w_win[r]);
        w_fillCount  = w_fillCount + 7'd1;
      end
    end
  end

  // Next LFSR value, used only while refilling.
  always_comb begin
    w_lfsrNext = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Merge the processed column back into the working board.
  always_comb begin
    w_boardNext = r_board;
    for (int r = 0; r < 8; r++) begin
      if (r_state == S_REFILL) begin
        w_boardNext[(r * 8 + int'(r_col)) * 3 +: 3] = w_fillCol[r];
      end else begin
        w_boardNext[(r * 8 + int'(r_col)) * 3 +: 3] = w_compCol[r];
      end
    end
  end

  // Control FSM: accept, compact 8 columns, refill 8 columns, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= 3'd0;
      r_lfsr      <= LFSR_SEED;
      r_board     <= 192'd0;
      r_refillCnt <= 7'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_board     <= board_in;
            r_col       <= 3'd0;
            r_refillCnt <= 7'd0;
            r_busy      <= 1'b1;
            r_state     <= S_COMPACT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_COMPACT: begin
          r_board <= w_boardNext;
          if (r_col == 3'd7) begin
            r_col   <= 3'd0;
            r_state <= S_REFILL;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        S_REFILL: begin
          r_board     <= w_boardNext;
          r_refillCnt <= r_refillCnt + w_fillCount;
          r_lfsr      <= w_lfsrNext;
          if (r_col == 3'd7) begin
            r_col   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign board_out  = r_board;
  assign busy       = r_busy;
  assign done       = r_done;
  assign refill_cnt = r_refillCnt;

endmodule

// File: tb/tb_gravity_refill.sv
// Scoreboard bench for gravity_refill: every accepted start pushes the expected
// settled board, refill count and done cycle; a monitor pops on each done pulse.
module tb_gravity_refill;

  localparam int          NC   = 6;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [191:0] board;
    int           cnt;
    int           doneCyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [191:0] board_in;
  logic [191:0] board_out;
  logic         busy;
  logic         done;
  logic [6:0]   refill_cnt;

  exp_t         expQ[$];
  exp_t         mE;
  int           mEmpty;
  int           total    = 0;
  int           bad      = 0;
  int           cyc      = 0;
  int           doneSeen = 0;
  int           doneBefore;
  logic [15:0]  modelLfsr;
  logic [191:0] b;

  gravity_refill #(
    .NUM_COLORS(NC),
    .EMPTY     (3'd0),
    .LFSR_SEED (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .board_in  (board_in),
    .board_out (board_out),
    .busy      (busy),
    .done      (done),
    .refill_cnt(refill_cnt)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [191:0] setCell(logic [191:0] bd, int r, int c, logic [2:0] v);
    bd[(r * 8 + c) * 3 +: 3] = v;
    return bd;
  endfunction

  function automatic logic [2:0] getCell(logic [191:0] bd, int r, int c);
    return bd[(r * 8 + c) * 3 +: 3];
  endfunction

  function automatic logic [191:0] randBoard(int emptyPct);
    logic [191:0] bd = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (int'($urandom_range(99)) >= emptyPct)
          bd = setCell(bd, r, c, 3'($urandom_range(7, 1)));
    return bd;
  endfunction

  // Reference model: gravity on each column via a queue, then column-by-column refill.
  task automatic modelSettle(input logic [191:0] bin, inout logic [15:0] lf,
                             output logic [191:0] bout, output int cnt);
    logic [2:0] q[$];
    int         empties;
    logic [2:0] win;
    bout = bin;
    cnt  = 0;
    for (int c = 0; c < 8; c++) begin
      q.delete();
      for (int r = 0; r < 8; r++)
        if (getCell(bin, r, c) != 3'd0) q.push_back(getCell(bin, r, c));
      empties = 8 - q.size();
      for (int r = 0; r < 8; r++)
        bout = setCell(bout, r, c, (r < empties) ? 3'd0 : q[r - empties]);
    end
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        if (getCell(bout, r, c) == 3'd0) begin
          if (r < 7) win = 3'((lf >> (2 * r)) & 16'h7);
          else       win = {lf[0], lf[15:14]};
          bout = setCell(bout, r, c, 3'((int'(win) % NC) + 1));
          cnt++;
        end
      end
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
  endtask

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive start with a board; must be called between clock edges while the DUT is idle or done.
  task automatic applyStimulus(input logic [191:0] bd);
    logic [191:0] eb;
    int           ec;
    start    = 1'b1;
    board_in = bd;
    @(posedge clk);
    #1;
    modelSettle(bd, modelLfsr, eb, ec);
    expQ.push_back('{eb, ec, cyc + 16});
    start    = 1'b0;
    board_in = {6{$urandom()}};
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    checkOutput("done_within_budget", 192'(done), 192'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    modelLfsr = SEED;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: on every done pulse compare against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      doneSeen++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
      end else begin
        mE = expQ.pop_front();
        checkOutput("board", board_out, mE.board);
        checkOutput("refill_cnt", 192'(refill_cnt), 192'(mE.cnt));
        checkOutput("done_cycle", 192'(cyc), 192'(mE.doneCyc));
        checkOutput("busy_low_in_done", 192'(busy), 192'd0);
        mEmpty = 0;
        for (int i = 0; i < 64; i++)
          if (board_out[i * 3 +: 3] == 3'd0) mEmpty++;
        checkOutput("no_empty_left", 192'(mEmpty), 192'd0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized boards.
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    board_in  = '0;
    modelLfsr = SEED;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_busy", 192'(busy), 192'd0);
    checkOutput("reset_done", 192'(done), 192'd0);
    checkOutput("reset_board", board_out, 192'd0);
    checkOutput("reset_refill_cnt", 192'(refill_cnt), 192'd0);

    // All-empty board straight after reset.
    @(negedge clk);
    applyStimulus(192'd0);
    waitDone(40);

    // Full board, rows coloured 1..7 then wrapping; includes the invalid code 7.
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b = setCell(b, r, c, 3'((r % 7) + 1));
    @(negedge clk);
    applyStimulus(b);
    waitDone(40);

    // Column 2 with one hole at the bottom, straight after reset.
    doReset();
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b = setCell(b, r, c, 3'd3);
    b = setCell(b, 0, 2, 3'd1); b = setCell(b, 1, 2, 3'd2);
    b = setCell(b, 2, 2, 3'd3); b = setCell(b, 3, 2, 3'd4);
    b = setCell(b, 4, 2, 3'd5); b = setCell(b, 5, 2, 3'd1);
    b = setCell(b, 6, 2, 3'd2); b = setCell(b, 7, 2, 3'd0);
    applyStimulus(b);
    waitDone(40);

    // All-empty again after a fresh reset must reproduce the seed colours.
    doReset();
    applyStimulus(192'd0);
    waitDone(40);

    // Column 5 alternating holes and tiles.
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b = setCell(b, r, c, 3'd2);
    for (int r = 0; r < 8; r += 2) b = setCell(b, r, 5, 3'd0);
    b = setCell(b, 1, 5, 3'd4); b = setCell(b, 3, 5, 3'd6);
    b = setCell(b, 5, 5, 3'd4); b = setCell(b, 7, 5, 3'd6);
    @(negedge clk);
    applyStimulus(b);
    waitDone(40);

    // Start pulses at E3 and E10 are ignored; start in the done cycle is accepted.
    @(negedge clk);
    applyStimulus(randBoard(40));
    repeat (3) @(negedge clk);
    start = 1'b1; board_in = randBoard(50);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; board_in = randBoard(50);
    @(negedge clk);
    start = 1'b0;
    waitDone(40);
    applyStimulus(randBoard(30));
    checkOutput("busy_after_done_restart", 192'(busy), 192'd1);
    waitDone(40);

    // Reset at E5 abandons the operation without a done pulse.
    @(negedge clk);
    applyStimulus(randBoard(30));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    modelLfsr  = SEED;
    doneBefore = doneSeen;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", 192'(busy), 192'd0);
    checkOutput("midreset_done", 192'(done), 192'd0);
    checkOutput("midreset_board", board_out, 192'd0);
    checkOutput("midreset_refill_cnt", 192'(refill_cnt), 192'd0);
    repeat (20) @(negedge clk);
    checkOutput("no_done_after_reset", 192'(doneSeen), 192'(doneBefore));
    applyStimulus(192'd0);
    waitDone(40);

    // Randomized boards, alternating back-to-back restarts with idle gaps.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) @(negedge clk);
      applyStimulus(randBoard(int'($urandom_range(90))));
      waitDone(40);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 192'(expQ.size()), 192'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
